// File: rtl/seq_detect_prog.sv
// ---------------------------------------------------------------------------
// seq_detect_prog
//   Programmable serial bit-sequence detector. A runtime-loaded pattern of
//   1..MAX_LEN bits is compared against a qualified serial input stream.
//   Overlapping and non-overlapping match modes are supported, and a
//   saturating counter tracks the number of matches.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (>= 2)
//   CNT_W    hit counter width
//   DEF_PAT  pattern after reset (low DEF_LEN bits significant)
//   DEF_LEN  pattern length after reset
//   LW       width of length fields (derived)
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   x        serial data bit
//   x_valid  x is sampled only while high
//   overlap  1 = overlapping matches, 0 = non-overlapping
//   load     latch pat_in/len_in and restart detection
//   pat_in   new pattern; bit len-1 is received first, bit 0 last
//   len_in   new pattern length (0 disables, > MAX_LEN clamps)
//   clr_cnt  clear hit counter
//   y        registered match pulse
//   hit_cnt  saturating match count
// ---------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN = 4,
  localparam int                LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   hit_cnt
);

  // Pattern / length configuration
  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;

  // History of received bits (r_sh[0] = newest) and number of valid bits
  logic [MAX_LEN-1:0] r_sh;
  logic [LW-1:0]      r_fill;

  // Outputs
  logic               r_y;
  logic [CNT_W-1:0]   r_hit_cnt;

  // Next-sample values
  logic [MAX_LEN-1:0] w_nsh;
  logic [LW-1:0]      w_nfill;
  logic [LW-1:0]      w_len_clamped;
  logic               w_eq;
  logic               w_match;
  logic               w_hit;

  assign w_nsh   = {r_sh[MAX_LEN-2:0], x};
  assign w_nfill = (r_fill == LW'(MAX_LEN)) ? r_fill : r_fill + 1'b1;

  assign w_len_clamped = (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;

  // Compare only the low r_len bits of the history against the pattern.
  always_comb begin
    w_eq = 1'b1;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((i < 32'(r_len)) && (w_nsh[i] != r_pat[i])) begin
        w_eq = 1'b0;
      end
    end
  end

  // Requiring enough fresh bits prevents stale zeros left by reset/load
  // (or consumed bits in non-overlapping mode) from completing a match.
  assign w_match = (r_len != '0) && (w_nfill >= r_len) && w_eq;
  assign w_hit   = !load && x_valid && w_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat     <= DEF_PAT;
      r_len     <= LW'(DEF_LEN);
      r_sh      <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      if (load) begin
        r_pat  <= pat_in;
        r_len  <= w_len_clamped;
        r_sh   <= '0;
        r_fill <= '0;
        r_y    <= 1'b0;
      end else if (x_valid) begin
        r_sh   <= w_nsh;
        r_y    <= w_match;
        // Non-overlapping mode consumes the completing bits.
        r_fill <= (w_match && !overlap) ? '0 : w_nfill;
      end else begin
        r_y <= 1'b0;
      end

      // A clear coinciding with a match keeps that match counted.
      if (clr_cnt) begin
        r_hit_cnt <= w_hit ? CNT_W'(1) : '0;
      end else if (w_hit && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
    end
  end

  assign y       = r_y;
  assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_seq_detect_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_prog
//   Directed self-checking bench for seq_detect_prog. Two instances share
//   stimulus: the default build and a CNT_W=2 build for saturation checks.
// ---------------------------------------------------------------------------
module tb_seq_detect_prog;

  logic       clk;
  logic       rst_n;
  logic       x;
  logic       x_valid;
  logic       overlap;
  logic       load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       clr_cnt;
  logic       y;
  logic [7:0] hit_cnt;
  logic       y2;
  logic [1:0] hit_cnt2;

  int n_cmp;
  int n_err;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .load(load), .pat_in(pat_in), .len_in(len_in), .clr_cnt(clr_cnt),
    .y(y), .hit_cnt(hit_cnt)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .load(load), .pat_in(pat_in), .len_in(len_in), .clr_cnt(clr_cnt),
    .y(y2), .hit_cnt(hit_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    x_valid = 1'b0;
    x       = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Load cycle with x_valid deliberately high: the bit must be ignored.
  task automatic do_load(input logic [7:0] p, input logic [3:0] l);
    load    = 1'b1;
    pat_in  = p;
    len_in  = l;
    x_valid = 1'b1;
    x       = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
    x_valid = 1'b0;
    x       = 1'b0;
    chk("load_y", {31'd0, y}, 32'd0);
  endtask

  // bits: '1'/'0' = valid bit, '-' = gap. yexp: expected y after each edge.
  task automatic run(input string tag, input string bits, input string yexp);
    for (int i = 0; i < bits.len(); i++) begin
      x_valid = (bits[i] != "-");
      x       = (bits[i] == "1");
      @(posedge clk); #1;
      chk($sformatf("%s_y%0d", tag, i), {31'd0, y}, (yexp[i] == "1") ? 32'd1 : 32'd0);
    end
    x_valid = 1'b0;
    x       = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b1;
    x       = 1'b0;
    x_valid = 1'b0;
    overlap = 1'b1;
    load    = 1'b0;
    pat_in  = 8'd0;
    len_in  = 4'd0;
    clr_cnt = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    chk("rst_y", {31'd0, y}, 32'd0);
    chk("rst_cnt", {24'd0, hit_cnt}, 32'd0);

    // Default 1011, overlapping
    overlap = 1'b1;
    run("ov1", "1011011", "0001001");
    chk("ov1_cnt", {24'd0, hit_cnt}, 32'd2);

    // Default 1011, non-overlapping
    do_reset();
    overlap = 1'b0;
    run("ov0", "1011011", "0001000");
    chk("ov0_cnt", {24'd0, hit_cnt}, 32'd1);

    // Pattern 111, overlapping: back-to-back y
    do_reset();
    overlap = 1'b1;
    do_load(8'b0000_0111, 4'd3);
    run("p111o", "11111", "00111");
    chk("p111o_cnt", {24'd0, hit_cnt}, 32'd3);

    // Pattern 111, non-overlapping
    do_reset();
    overlap = 1'b0;
    do_load(8'b0000_0111, 4'd3);
    run("p111n", "11111", "00100");
    chk("p111n_cnt", {24'd0, hit_cnt}, 32'd1);

    // x_valid gaps
    do_reset();
    overlap = 1'b1;
    run("gap", "1-01--1", "0000001");
    chk("gap_cnt", {24'd0, hit_cnt}, 32'd1);

    // Saturation on the CNT_W=2 build, five matches
    do_reset();
    overlap = 1'b1;
    run("sat", "1011011011011011", "0001001001001001");
    chk("sat_cnt8", {24'd0, hit_cnt}, 32'd5);
    chk("sat_cnt2", {30'd0, hit_cnt2}, 32'd3);
    run("sat_b", "01", "00");
    clr_cnt = 1'b1;
    run("clrhit", "1", "1");
    clr_cnt = 1'b0;
    chk("clrhit_cnt2", {30'd0, hit_cnt2}, 32'd1);
    chk("clrhit_cnt8", {24'd0, hit_cnt}, 32'd1);
    clr_cnt = 1'b1;
    run("clr", "-", "0");
    clr_cnt = 1'b0;
    chk("clr_cnt2", {30'd0, hit_cnt2}, 32'd0);
    chk("clr_cnt8", {24'd0, hit_cnt}, 32'd0);

    // Mid-pattern reset discards history
    do_reset();
    overlap = 1'b1;
    run("mrst_a", "101", "000");
    do_reset();
    chk("mrst_y", {31'd0, y}, 32'd0);
    run("mrst_b", "1", "0");
    run("mrst_c", "1011", "0001");
    chk("mrst_cnt", {24'd0, hit_cnt}, 32'd1);

    // len 0 disables detection
    do_reset();
    do_load(8'd0, 4'd0);
    run("len0", "00001111011", "00000000000");
    chk("len0_cnt", {24'd0, hit_cnt}, 32'd0);

    // len 15 clamps to 8
    do_reset();
    do_load(8'b1010_0110, 4'd15);
    run("len15", "10100110", "00000001");
    chk("len15_cnt", {24'd0, hit_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
